// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word width, RAM handshake state and the memory arbiter's grant state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating up-counter with clear priority; flags when the configured limit is reached.
module arb_streak_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count_reg < LIMIT_W)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign at_limit = (count_reg == LIMIT_W);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one wait-stated RAM port between instruction fetch and data access, data first with a fetch streak guard.
// Optional MEM_ARBITER_STATS_EN adds icount/dcount/stallcount counters.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int DSTREAK = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
`ifdef MEM_ARBITER_STATS_EN
    ,
    output logic [31:0] icount,
    output logic [31:0] dcount,
    output logic [31:0] stallcount
`endif
);

    arb_state_t state_reg;
    arb_state_t state_next;
    ramstate_t  rs;
    logic       dreq;
    logic       access;
    logic       icomp;
    logic       dcomp;
    logic       streak_full;

    assign rs     = ramstate_t'(ramstate);
    assign dreq   = dREN | dWEN;
    assign access = (rs == ACCESS);
    assign icomp  = (state_reg == IGNT) && access && iREN;
    assign dcomp  = (state_reg == DGNT) && access && dreq;

    arb_streak_counter #(
        .WIDTH (4),
        .LIMIT (DSTREAK)
    ) u_streak (
        .clk      (CLK),
        .rst_n    (nRST),
        .inc      (dcomp & iREN),
        .clr      (icomp | ((state_reg == IDLE) & ~iREN)),
        .at_limit (streak_full)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iload      = '0;
        dload      = '0;
        case (state_reg)
            IDLE: begin
                if (dreq && !(iREN && streak_full)) begin
                    state_next = DGNT;
                end else if (iREN) begin
                    state_next = IGNT;
                end
            end
            IGNT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                iload   = ramload;
                // BUSY/ERROR hold the grant; completion or a dropped request releases it
                if (access || !iREN) begin
                    state_next = IDLE;
                end
            end
            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                dload    = ramload;
                ramWEN   = dWEN;
                ramREN   = ~dWEN;
                if (access || !dreq) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Waits are also forced low while reset is held, so a stalled requester sees no wait during reset
    assign iwait = nRST & iREN & ~((state_reg == IGNT) & access);
    assign dwait = nRST & dreq & ~((state_reg == DGNT) & access);

`ifdef MEM_ARBITER_STATS_EN
    logic [2:0] stat_inc;

    assign stat_inc = {iwait | dwait, dcomp, icomp};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_stat
            logic [31:0] cnt_reg;
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    cnt_reg <= '0;
                end else if (stat_inc[gi]) begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end
        end
    endgenerate

    assign icount     = g_stat[0].cnt_reg;
    assign dcount     = g_stat[1].cnt_reg;
    assign stallcount = g_stat[2].cnt_reg;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus hand-written contention, streak, abort and reset sequences.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [1:0]  ramstate;
`ifdef MEM_ARBITER_STATS_EN
    logic [31:0] icount, dcount, stallcount;
`endif

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.DSTREAK(4)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
`ifdef MEM_ARBITER_STATS_EN
        ,
        .icount     (icount),
        .dcount     (dcount),
        .stallcount (stallcount)
`endif
    );

    // field order: ir, dr, dw, err, addr, store, load, busy, exp_ren, exp_wen, exp_addr, exp_store
    typedef struct {
        logic        ir;
        logic        dr;
        logic        dw;
        logic        err;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] load;
        int          busy;
        logic        exp_ren;
        logic        exp_wen;
        logic [31:0] exp_addr;
        logic [31:0] exp_store;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        string order;
        int    grants;
        bit    prev_i;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h8C01_0004, 2,
                    1'b1, 1'b0, 32'h0000_0040, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h5555_AAAA, 32'h1234_5678, 0,
                    1'b1, 1'b0, 32'h0000_0100, 32'h5555_AAAA};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0, 1,
                    1'b0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0204, 32'hCAFE_F00D, 32'h0, 0,
                    1'b0, 1'b1, 32'h0000_0204, 32'hCAFE_F00D};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0080, 32'h0, 32'h0BAD_F00D, 3,
                    1'b1, 1'b0, 32'h0000_0080, 32'h0};

        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 32'hFFFF_FFFF;
        ramstate = FREE;
        nRST = 1'b1;
        #2;
        nRST = 1'b0;
        iREN = 1'b1;
        dREN = 1'b1;

        // reset held with both requests pending
        step();
        step();
        chk("rst ramREN", ramREN, 0);
        chk("rst ramWEN", ramWEN, 0);
        chk("rst ramaddr", ramaddr, 0);
        chk("rst ramstore", ramstore, 0);
        chk("rst iwait", iwait, 0);
        chk("rst dwait", dwait, 0);
        chk("rst iload", iload, 0);
        chk("rst dload", dload, 0);
        chk("rst state", dut.state_reg, IDLE);
        iREN = 0; dREN = 0;
        step();
        nRST = 1'b1;
        step();
        $display("txn reset: done");

        for (int k = 0; k < 5; k++) begin
            iREN    = vecs[k].ir;
            dREN    = vecs[k].dr;
            dWEN    = vecs[k].dw;
            iaddr   = vecs[k].ir ? vecs[k].addr : 32'h0;
            daddr   = vecs[k].ir ? 32'h0 : vecs[k].addr;
            dstore  = vecs[k].store;
            ramload = vecs[k].load;
            ramstate = FREE;
            #1;
            chk($sformatf("v%0d arb ramREN", k), ramREN, 0);
            chk($sformatf("v%0d arb wait", k), vecs[k].ir ? iwait : dwait, 1);
            for (int c = 1; c <= vecs[k].busy + 1; c++) begin
                step();
                if (c <= vecs[k].busy) ramstate = vecs[k].err ? ERROR : BUSY;
                else                   ramstate = ACCESS;
                #1;
                chk($sformatf("v%0d c%0d ramREN", k, c), ramREN, vecs[k].exp_ren);
                chk($sformatf("v%0d c%0d ramWEN", k, c), ramWEN, vecs[k].exp_wen);
                chk($sformatf("v%0d c%0d ramaddr", k, c), ramaddr, vecs[k].exp_addr);
                chk($sformatf("v%0d c%0d ramstore", k, c), ramstore, vecs[k].exp_store);
                chk($sformatf("v%0d c%0d wait", k, c), vecs[k].ir ? iwait : dwait,
                    (c <= vecs[k].busy) ? 32'd1 : 32'd0);
            end
            chk($sformatf("v%0d load", k), vecs[k].ir ? iload : dload, vecs[k].load);
            chk($sformatf("v%0d other load", k), vecs[k].ir ? dload : iload, 0);
            step();
            iREN = 0; dREN = 0; dWEN = 0;
            ramstate = FREE;
            #1;
            chk($sformatf("v%0d after ramREN", k), ramREN, 0);
            chk($sformatf("v%0d after ramWEN", k), ramWEN, 0);
            $display("txn v%0d: ir=%0b dr=%0b dw=%0b addr=0x%08h busy=%0d", k,
                     vecs[k].ir, vecs[k].dr, vecs[k].dw, vecs[k].addr, vecs[k].busy);
        end

        // contention: data wins, fetch follows after one idle cycle
        step();
        iREN = 1; dREN = 1; iaddr = 32'h44; daddr = 32'h100; ramload = 32'hA5A5_0001;
        ramstate = FREE;
        step();
        ramstate = ACCESS;
        #1;
        chk("cont dgnt ramaddr", ramaddr, 32'h100);
        chk("cont dwait", dwait, 0);
        chk("cont iwait held", iwait, 1);
        step();
        dREN = 0; ramstate = FREE;
        #1;
        chk("cont idle ramREN", ramREN, 0);
        chk("cont idle iwait", iwait, 1);
        step();
        ramstate = ACCESS;
        #1;
        chk("cont ignt ramaddr", ramaddr, 32'h44);
        chk("cont ignt iwait", iwait, 0);
        chk("cont ignt iload", iload, 32'hA5A5_0001);
        step();
        iREN = 0; ramstate = FREE;
        step();
        $display("txn contention: done");

        // starvation guard with both requests held
        iREN = 1; dREN = 1; dWEN = 0; iaddr = 32'h400; daddr = 32'h500; ramstate = FREE;
        order = "";
        grants = 0;
        prev_i = 0;
        for (int c = 0; c < 40 && grants < 7; c++) begin
            step();
            if (ramREN) begin
                if (ramaddr == 32'h400) begin
                    order = {order, "I"};
                    chk("starve streak at fetch", {28'h0, dut.u_streak.count_reg}, 4);
                    prev_i = 1;
                end else begin
                    order = {order, "D"};
                end
                grants++;
                ramstate = ACCESS;
            end else begin
                ramstate = FREE;
                if (prev_i) begin
                    chk("starve streak cleared", {28'h0, dut.u_streak.count_reg}, 0);
                    prev_i = 0;
                end
            end
        end
        step();
        iREN = 0; dREN = 0; ramstate = FREE;
        total++;
        if (order != "DDDDIDD") begin
            bad++;
            $display("FAIL starve order: got %s expected DDDDIDD", order);
        end
        step();
        $display("txn starvation: order=%s", order);

        // abort: read dropped during BUSY
        dREN = 1; daddr = 32'h300; ramstate = FREE;
        step();
        ramstate = BUSY;
        #1;
        chk("abort ramREN on", ramREN, 1);
        chk("abort dwait busy", dwait, 1);
        step();
        dREN = 0;
        step();
        chk("abort ramREN off", ramREN, 0);
        chk("abort state", dut.state_reg, IDLE);
        ramstate = FREE;
        step();
        $display("txn abort: done");

        // async reset in DGNT/BUSY
        dREN = 1; daddr = 32'h600;
        step();
        ramstate = BUSY;
        #1;
        chk("arst pre ramREN", ramREN, 1);
        #1;
        nRST = 0;
        #1;
        chk("arst ramREN", ramREN, 0);
        chk("arst ramaddr", ramaddr, 0);
        chk("arst dwait", dwait, 0);
        chk("arst state", dut.state_reg, IDLE);
        dREN = 0; ramstate = FREE;
        step();
        nRST = 1;
        step();
        iREN = 1; iaddr = 32'h700; ramload = 32'h1111_2222;
        step();
        ramstate = ACCESS;
        #1;
        chk("arst fetch ramaddr", ramaddr, 32'h700);
        chk("arst fetch iwait", iwait, 0);
        chk("arst fetch iload", iload, 32'h1111_2222);
        step();
        iREN = 0; ramstate = FREE;
        dREN = 1; daddr = 32'h800; ramload = 32'h3333_4444;
        step();
        ramstate = BUSY;
        step();
        ramstate = ACCESS;
        #1;
        chk("arst read dwait", dwait, 0);
        chk("arst read dload", dload, 32'h3333_4444);
        step();
        dREN = 0; ramstate = FREE;
        #1;
`ifdef MEM_ARBITER_STATS_EN
        chk("stats icount", icount, 1);
        chk("stats dcount", dcount, 1);
        chk("stats stallcount", stallcount, 3);
`endif
        $display("txn async reset: done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
